// File: rtl/up2_uart_rx.sv
// rtl/up2_uart_rx.sv - UART receiver (8N1, optional even parity via UP2_UART_RX_PARITY_EN)
module up2_uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
`ifdef UP2_UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
`ifdef UP2_UART_RX_PARITY_EN
        ,
        S_PARITY = 3'd5
`endif
    } state_t;

    state_t        state, state_n;
    logic          rx_meta, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    data_n;
    logic          valid_n, frame_err_n;
`ifdef UP2_UART_RX_PARITY_EN
    logic          par, par_n;
    logic          parity_err_n;
`endif

    // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register and registered output strobes
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UP2_UART_RX_PARITY_EN
            par        <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            data       <= data_n;
            valid      <= valid_n;
            frame_err  <= frame_err_n;
`ifdef UP2_UART_RX_PARITY_EN
            par        <= par_n;
            parity_err <= parity_err_n;
`endif
        end
    end

    // Next-state logic: sample each bit at its midpoint, counted from the mid start bit
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        data_n      = data;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;
`ifdef UP2_UART_RX_PARITY_EN
        par_n        = par;
        parity_err_n = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (cnt == CNT_MID) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = S_DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UP2_UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef UP2_UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    par_n   = rx_s;
                    state_n = S_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        frame_err_n = 1'b1;
                        state_n     = S_BREAK;
`ifdef UP2_UART_RX_PARITY_EN
                    end else if ((^shreg) != par) begin
                        parity_err_n = 1'b1;
                        state_n      = S_IDLE;
`endif
                    end else begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_up2_uart_rx.sv
// tb/tb_up2_uart_rx.sv - directed table-driven bench for up2_uart_rx
module tb_up2_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       nRst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic       perr;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_ferr  = 0;
    int n_perr  = 0;
    logic [7:0] got[$];
    logic prev_any = 1'b0;

    up2_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UP2_UART_RX_PARITY_EN
        ,
        .parity_err(perr)
`endif
    );

`ifndef UP2_UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       par_ok;
        int         exp_v;
        int         exp_f;
        int         exp_p;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse monitor: counts strobes, logs received bytes, checks exclusivity and single-cycle width
    always @(negedge clk) begin
        if (nRst) begin
            if (valid) begin
                n_valid++;
                got.push_back(data);
            end
            if (frame_err) n_ferr++;
            if (perr) n_perr++;
            if (valid || frame_err || perr) begin
                n_tests++;
                if ((int'(valid) + int'(frame_err) + int'(perr)) > 1 || prev_any) begin
                    n_fail++;
                    $display("FAIL pulse_excl: valid=%0b frame_err=%0b parity_err=%0b prev=%0b, expected single one-cycle pulse",
                             valid, frame_err, perr, prev_any);
                end
            end
            prev_any = valid | frame_err | perr;
        end else begin
            prev_any = 1'b0;
        end
    end

    task automatic line(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(b[i], CPB);
`ifdef UP2_UART_RX_PARITY_EN
        line((^b) ^ ~par_ok, CPB);
`endif
        line(stop, CPB);
        rx = 1'b1;
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic stop, input logic par_ok,
                                input int ev, input int ef, input int ep, input logic [7:0] ed);
        vec_t v;
        v.b = b; v.stop = stop; v.par_ok = par_ok;
        v.exp_v = ev; v.exp_f = ef; v.exp_p = ep; v.exp_d = ed;
        return v;
    endfunction

    initial begin
        int v0, f0, p0;
        vecs.push_back(mk(8'hA5, 1'b1, 1'b1, 1, 0, 0, 8'hA5));
        vecs.push_back(mk(8'h3C, 1'b0, 1'b1, 0, 1, 0, 8'hA5));
        vecs.push_back(mk(8'h5A, 1'b1, 1'b1, 1, 0, 0, 8'h5A));
        vecs.push_back(mk(8'hC3, 1'b1, 1'b1, 1, 0, 0, 8'hC3));
`ifdef UP2_UART_RX_PARITY_EN
        vecs.push_back(mk(8'h07, 1'b1, 1'b1, 1, 0, 0, 8'h07));
        vecs.push_back(mk(8'h07, 1'b1, 1'b0, 0, 0, 1, 8'h07));
`endif

        rx   = 1'b1;
        nRst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        nRst = 1'b1;
        line(1'b1, 20);

        foreach (vecs[k]) begin
            v0 = n_valid; f0 = n_ferr; p0 = n_perr;
            send_frame(vecs[k].b, vecs[k].stop, vecs[k].par_ok);
            if (!vecs[k].stop) begin
                line(1'b0, 40);
                check($sformatf("v%0d_busy_in_break", k), int'(busy), 1);
            end
            line(1'b1, 20);
            check($sformatf("v%0d_valid_cnt", k), n_valid - v0, vecs[k].exp_v);
            check($sformatf("v%0d_ferr_cnt", k), n_ferr - f0, vecs[k].exp_f);
            check($sformatf("v%0d_perr_cnt", k), n_perr - p0, vecs[k].exp_p);
            check($sformatf("v%0d_data", k), int'(data), int'(vecs[k].exp_d));
            check($sformatf("v%0d_busy_idle", k), int'(busy), 0);
        end

        // Short glitch must not produce any strobe and busy must drop quickly
        v0 = n_valid; f0 = n_ferr;
        line(1'b0, 4);
        line(1'b1, 10);
        check("glitch_busy", int'(busy), 0);
        line(1'b1, 30);
        check("glitch_valid_cnt", n_valid - v0, 0);
        check("glitch_ferr_cnt", n_ferr - f0, 0);

        // Back-to-back frames, no idle gap
        v0 = n_valid;
        got.delete();
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        line(1'b1, 20);
        check("b2b_valid_cnt", n_valid - v0, 2);
        if (got.size() == 2) begin
            check("b2b_first", int'(got[0]), 8'h00);
            check("b2b_second", int'(got[1]), 8'hFF);
        end else begin
            check("b2b_bytes_logged", got.size(), 2);
        end

        // Reset during bit 4 of 0x81, then a full 0x81
        line(1'b0, CPB);
        for (int i = 0; i < 4; i++) line(logic'(i == 0), CPB);
        line(1'b0, CPB / 2);
        check("mid_busy_before_reset", int'(busy), 1);
        nRst = 1'b0;
        #1;
        check("mid_reset_data", int'(data), 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_valid", int'(valid), 0);
        check("mid_reset_ferr", int'(frame_err), 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        line(1'b1, 20);
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h81, 1'b1, 1'b1);
        line(1'b1, 20);
        check("after_reset_valid_cnt", n_valid - v0, 1);
        check("after_reset_ferr_cnt", n_ferr - f0, 0);
        check("after_reset_data", int'(data), 8'h81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
